// File: rtl/fetch_unit.sv
// Instruction-byte prefetcher: boots from the reset vector, then keeps a
// small byte queue filled from memory ahead of the control FSM.
// Ports:
//   ph1, reset                        : clock, sync active-high reset
//   mem_addr, mem_rd, mem_rdy, mem_data : single-outstanding memory read port
//   fetch_req, fetch_ack, data_out    : byte delivery to the control FSM
//   pc_load, pc_in, pc                : redirect and address of the head byte
module fetch_unit #(
  parameter int          DEPTH        = 2,
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        ph1,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_data,
  input  logic        fetch_req,
  output logic        fetch_ack,
  output logic [7:0]  data_out,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  output logic [15:0] pc
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [15:0] VEC_HI_ADDR = RESET_VECTOR + 16'd1;

  typedef enum logic [1:0] {
    VEC_LO,
    VEC_HI,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [15:0]   fetch_addr;
  logic [7:0]    vec_lo;
  logic [7:0]    q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    mem_rd   = 1'b0;
    mem_addr = fetch_addr;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      VEC_LO: begin
        mem_rd   = 1'b1;
        mem_addr = RESET_VECTOR;
        if (mem_rdy) state_d = VEC_HI;
      end
      VEC_HI: begin
        mem_rd   = 1'b1;
        mem_addr = VEC_HI_ADDR;
        if (mem_rdy) state_d = RUN;
      end
      RUN: begin
        mem_rd = (count < FULL);
        push   = mem_rd && mem_rdy && !pc_load;
        // Pop looks only at the registered count, so a byte
        // arriving this cycle cannot be delivered until the next.
        pop    = fetch_req && (count != '0) && !pc_load;
      end
      default: state_d = VEC_LO;
    endcase
  end

  assign fetch_ack = pop;
  assign data_out  = q[head];

  always_ff @(posedge ph1) begin
    if (reset) begin
      state_q    <= VEC_LO;
      pc         <= 16'h0000;
      fetch_addr <= 16'h0000;
      count      <= '0;
      head       <= '0;
      tail       <= '0;
      vec_lo     <= 8'h00;
      for (int i = 0; i < DEPTH; i++) q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        VEC_LO: begin
          if (mem_rdy) vec_lo <= mem_data;
        end
        VEC_HI: begin
          if (mem_rdy) begin
            pc         <= {mem_data, vec_lo};
            fetch_addr <= {mem_data, vec_lo};
          end
        end
        RUN: begin
          if (pc_load) begin
            // Flush; any byte returned this cycle is dropped.
            pc         <= pc_in;
            fetch_addr <= pc_in;
            count      <= '0;
            head       <= tail;
          end else begin
            if (push) begin
              q[tail]    <= mem_data;
              tail       <= wrap_inc(tail);
              fetch_addr <= fetch_addr + 16'd1;
            end
            if (pop) begin
              head <= wrap_inc(head);
              pc   <= pc + 16'd1;
            end
            unique case ({push, pop})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for boot/fill/redirect/wrap/
// reset, then a randomized stream checked through a byte scoreboard.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        ph1 = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_rdy;
  logic [7:0]  mem_data;
  logic        fetch_req;
  logic        fetch_ack;
  logic [7:0]  data_out;
  logic        pc_load;
  logic [15:0] pc_in;
  logic [15:0] pc;

  int checks = 0;
  int failures = 0;

  fetch_unit #(
    .DEPTH(DEPTH),
    .RESET_VECTOR(16'hFFFC)
  ) dut (
    .ph1(ph1),
    .reset(reset),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdy(mem_rdy),
    .mem_data(mem_data),
    .fetch_req(fetch_req),
    .fetch_ack(fetch_ack),
    .data_out(data_out),
    .pc_load(pc_load),
    .pc_in(pc_in),
    .pc(pc)
  );

  always #5 ph1 = ~ph1;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h00;
    if (a == 16'hFFFD) return 8'h80;
    if (a == 16'h8000) return 8'hA9;
    if (a == 16'h8001) return 8'h05;
    return a[7:0] ^ (a[15:8] + 8'h3C);
  endfunction

  // Memory answers the current address whenever the bench grants rdy.
  always_comb mem_data = mem_model(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        req;
    logic        ld;
    logic [15:0] ldv;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_ack;
    logic [15:0] e_pc;
    logic        chk_d;
    logic [7:0]  e_d;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, req, ld, input logic [15:0] ldv, input logic rdy,
    input logic e_rd, input logic [15:0] e_addr, input logic e_ack,
    input logic [15:0] e_pc, input logic chk_d, input logic [7:0] e_d);
    vec_t v;
    v.rst = rst; v.req = req; v.ld = ld; v.ldv = ldv; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_ack = e_ack;
    v.e_pc = e_pc; v.chk_d = chk_d; v.e_d = e_d;
    return v;
  endfunction

  vec_t tv [20];

  // Random-phase reference state.
  byte unsigned sb [$];
  logic [15:0] m_pc;
  logic [15:0] m_fa;

  initial begin
    //           rst req ld  ldv      rdy  rd  addr     ack pc       cd d
    tv[0]  = mk(0, 0, 0, 16'h0,    0,   1, 16'hFFFC, 0, 16'h0000, 1, 8'h00);
    tv[1]  = mk(0, 0, 0, 16'h0,    1,   1, 16'hFFFC, 0, 16'h0000, 0, 8'h00);
    tv[2]  = mk(0, 0, 0, 16'h0,    1,   1, 16'hFFFD, 0, 16'h0000, 0, 8'h00);
    tv[3]  = mk(0, 0, 0, 16'h0,    1,   1, 16'h8000, 0, 16'h8000, 0, 8'h00);
    tv[4]  = mk(0, 0, 0, 16'h0,    1,   1, 16'h8001, 0, 16'h8000, 1, 8'hA9);
    tv[5]  = mk(0, 0, 0, 16'h0,    1,   0, 16'h8002, 0, 16'h8000, 1, 8'hA9);
    tv[6]  = mk(0, 1, 0, 16'h0,    1,   0, 16'h8002, 1, 16'h8000, 1, 8'hA9);
    tv[7]  = mk(0, 1, 0, 16'h0,    1,   1, 16'h8002, 1, 16'h8001, 1, 8'h05);
    tv[8]  = mk(0, 1, 1, 16'h1234, 1,   1, 16'h8003, 0, 16'h8002, 0, 8'h00);
    tv[9]  = mk(0, 1, 0, 16'h0,    0,   1, 16'h1234, 0, 16'h1234, 0, 8'h00);
    tv[10] = mk(0, 0, 1, 16'hFFFF, 0,   1, 16'h1234, 0, 16'h1234, 0, 8'h00);
    tv[11] = mk(0, 1, 0, 16'h0,    1,   1, 16'hFFFF, 0, 16'hFFFF, 0, 8'h00);
    tv[12] = mk(0, 1, 0, 16'h0,    1,   1, 16'h0000, 1, 16'hFFFF, 1,
                mem_model(16'hFFFF));
    tv[13] = mk(0, 1, 0, 16'h0,    0,   1, 16'h0001, 1, 16'h0000, 1,
                mem_model(16'h0000));
    tv[14] = mk(0, 1, 0, 16'h0,    0,   1, 16'h0001, 0, 16'h0001, 0, 8'h00);
    tv[15] = mk(1, 1, 1, 16'h5555, 1,   1, 16'h0001, 0, 16'h0001, 0, 8'h00);
    tv[16] = mk(0, 0, 0, 16'h0,    0,   1, 16'hFFFC, 0, 16'h0000, 1, 8'h00);
    tv[17] = mk(0, 1, 1, 16'h5555, 1,   1, 16'hFFFC, 0, 16'h0000, 0, 8'h00);
    tv[18] = mk(0, 1, 1, 16'h5555, 1,   1, 16'hFFFD, 0, 16'h0000, 0, 8'h00);
    tv[19] = mk(0, 1, 0, 16'h0,    0,   1, 16'h8000, 0, 16'h8000, 0, 8'h00);

    reset = 1'b1;
    fetch_req = 1'b0;
    pc_load = 1'b0;
    pc_in = 16'h0;
    mem_rdy = 1'b0;
    @(posedge ph1);
    #1;

    for (int i = 0; i < 20; i++) begin
      reset     = tv[i].rst;
      fetch_req = tv[i].req;
      pc_load   = tv[i].ld;
      pc_in     = tv[i].ldv;
      mem_rdy   = tv[i].rdy;
      #3;
      chk($sformatf("v%0d_mem_rd", i), 32'(mem_rd), 32'(tv[i].e_rd));
      chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr),
          32'(tv[i].e_addr));
      chk($sformatf("v%0d_ack", i), 32'(fetch_ack), 32'(tv[i].e_ack));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tv[i].e_pc));
      if (tv[i].chk_d)
        chk($sformatf("v%0d_data", i), 32'(data_out), 32'(tv[i].e_d));
      @(posedge ph1);
      #1;
    end

    // Randomized stream: RUN at 8000 with an empty queue.
    reset = 1'b0;
    m_pc = 16'h8000;
    m_fa = 16'h8000;
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      logic e_rd;
      logic e_ack;
      fetch_req = ($urandom_range(0, 3) != 0);
      mem_rdy   = ($urandom_range(0, 2) != 0);
      pc_load   = ($urandom_range(0, 19) == 0);
      pc_in     = ($urandom_range(0, 1) != 0) ? 16'hFFFE
                                              : 16'($urandom);
      #3;
      e_rd  = (sb.size() < DEPTH);
      e_ack = fetch_req && (sb.size() != 0) && !pc_load;
      chk($sformatf("r%0d_mem_rd", c), 32'(mem_rd), 32'(e_rd));
      if (e_rd)
        chk($sformatf("r%0d_mem_addr", c), 32'(mem_addr), 32'(m_fa));
      chk($sformatf("r%0d_ack", c), 32'(fetch_ack), 32'(e_ack));
      chk($sformatf("r%0d_pc", c), 32'(pc), 32'(m_pc));
      if (e_ack)
        chk($sformatf("r%0d_data", c), 32'(data_out), 32'(sb[0]));
      @(posedge ph1);
      if (pc_load) begin
        sb.delete();
        m_pc = pc_in;
        m_fa = pc_in;
      end else begin
        if (e_ack) begin
          void'(sb.pop_front());
          m_pc = m_pc + 16'd1;
        end
        if (e_rd && mem_rdy) begin
          sb.push_back(mem_model(m_fa));
          m_fa = m_fa + 16'd1;
        end
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
